// File: rtl/iob_timer_alarm_ctrl_if.sv
// Configuration port of the alarm scheduler: valid/ready request carrying channel, arm/disarm,
// deadline and reload period.
interface iob_timer_alarm_ctrl_if #(
    parameter int CH_W   = 2,
    parameter int TIME_W = 64
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic              cfg_arm;
    logic [TIME_W-1:0] cfg_deadline;
    logic [TIME_W-1:0] cfg_period;

    modport master (
        output cfg_valid, cfg_ch, cfg_arm, cfg_deadline, cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_arm, cfg_deadline, cfg_period,
        output cfg_ready
    );
endinterface

// File: rtl/iob_timer_alarm_ctrl.sv
// Multi-channel alarm scheduler: one shared 64-bit comparator visited round-robin by a scanner.
// Optional periodic auto-reload is enabled by defining TIMER_ALARM_PERIODIC_EN.
module iob_timer_alarm_ctrl #(
    parameter int N_CH   = 4,
    parameter int CH_W   = $clog2(N_CH),
    parameter int TIME_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TIME_W-1:0]     timer_value,
    iob_timer_alarm_ctrl_if.slave cfg,
    input  logic [N_CH-1:0]       irq_mask,
    input  logic [N_CH-1:0]       pend_clr,
    output logic [N_CH-1:0]       pending,
    output logic [N_CH-1:0]       overrun,
    output logic [N_CH-1:0]       armed,
    output logic [CH_W-1:0]       scan_ch,
    output logic                  interrupt
);
    logic [TIME_W-1:0] deadline [N_CH];
`ifdef TIMER_ALARM_PERIODIC_EN
    logic [TIME_W-1:0] period [N_CH];
`else
    logic unused_period;
    assign unused_period = ^cfg.cfg_period;
`endif

    logic            vld_p1;
    logic [CH_W-1:0] ch_p1;
    logic            cfg_fire;
    logic            hit_p0;
    logic            kill_p0;

    // A write to the channel being written back by stage 2 is held off for that cycle.
    assign cfg.cfg_ready = !(vld_p1 && (ch_p1 == cfg.cfg_ch));
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
    assign interrupt     = |(pending & irq_mask);

    // Stage 1: compare the scanned channel; a config write to it this cycle kills the hit
    assign hit_p0  = armed[scan_ch] && (timer_value >= deadline[scan_ch]);
    assign kill_p0 = cfg_fire && (cfg.cfg_ch == scan_ch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ch <= '0;
            vld_p1  <= 1'b0;
            ch_p1   <= '0;
            armed   <= '0;
            pending <= '0;
            overrun <= '0;
            for (int k = 0; k < N_CH; k++) begin
                deadline[k] <= '0;
`ifdef TIMER_ALARM_PERIODIC_EN
                period[k]   <= '0;
`endif
            end
        end else begin
            scan_ch <= (scan_ch == CH_W'(N_CH - 1)) ? '0 : scan_ch + CH_W'(1);
            vld_p1  <= hit_p0 && !kill_p0;
            ch_p1   <= scan_ch;

            // Stage 2: writeback of the registered hit; config and writeback never share a channel
            for (int k = 0; k < N_CH; k++) begin
                if (vld_p1 && (ch_p1 == CH_W'(k))) begin
                    pending[k] <= 1'b1;
                    if (pending[k]) begin
                        overrun[k] <= 1'b1;
                    end else if (pend_clr[k]) begin
                        overrun[k] <= 1'b0;
                    end
`ifdef TIMER_ALARM_PERIODIC_EN
                    if (period[k] == '0) begin
                        armed[k] <= 1'b0;
                    end else begin
                        deadline[k] <= deadline[k] + period[k];
                    end
`else
                    armed[k] <= 1'b0;
`endif
                end else if (cfg_fire && (cfg.cfg_ch == CH_W'(k))) begin
                    if (cfg.cfg_arm) begin
                        armed[k]    <= 1'b1;
                        deadline[k] <= cfg.cfg_deadline;
`ifdef TIMER_ALARM_PERIODIC_EN
                        period[k]   <= cfg.cfg_period;
`endif
                        pending[k]  <= 1'b0;
                        overrun[k]  <= 1'b0;
                    end else begin
                        armed[k] <= 1'b0;
                        if (pend_clr[k]) begin
                            pending[k] <= 1'b0;
                            overrun[k] <= 1'b0;
                        end
                    end
                end else if (pend_clr[k]) begin
                    pending[k] <= 1'b0;
                    overrun[k] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_iob_timer_alarm_ctrl.sv
// Self-checking bench for iob_timer_alarm_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the alarm rules.
module tb_iob_timer_alarm_ctrl;
    localparam int N_CH   = 4;
    localparam int CH_W   = 2;
    localparam int TIME_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [TIME_W-1:0] timer_value = '0;
    logic [N_CH-1:0]   irq_mask = '0;
    logic [N_CH-1:0]   pend_clr = '0;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   overrun;
    logic [N_CH-1:0]   armed;
    logic [CH_W-1:0]   scan_ch;
    logic              interrupt;

    iob_timer_alarm_ctrl_if #(.CH_W(CH_W), .TIME_W(TIME_W)) cfg_if ();

    iob_timer_alarm_ctrl #(.N_CH(N_CH), .CH_W(CH_W), .TIME_W(TIME_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .timer_value(timer_value),
        .cfg        (cfg_if),
        .irq_mask   (irq_mask),
        .pend_clr   (pend_clr),
        .pending    (pending),
        .overrun    (overrun),
        .armed      (armed),
        .scan_ch    (scan_ch),
        .interrupt  (interrupt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-channel alarm records, the channel being visited, and the hit in flight.
    logic [N_CH-1:0]   m_armed, m_pending, m_overrun;
    logic [TIME_W-1:0] m_deadline [N_CH];
    logic [TIME_W-1:0] m_period   [N_CH];
    int                m_scan;
    int                m_inflight;
    bit                last_accept;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = '0; m_pending = '0; m_overrun = '0;
        for (int k = 0; k < N_CH; k++) begin
            m_deadline[k] = '0;
            m_period[k]   = '0;
        end
        m_scan = 0;
        m_inflight = -1;
        last_accept = 0;
    endtask

    function automatic bit model_ready();
        return !(m_inflight >= 0 && m_inflight == int'(cfg_if.cfg_ch));
    endfunction

    task automatic model_advance(input bit rdy);
        bit acc;
        int cc;
        int nxt;
        int h;
        logic [N_CH-1:0] old_p;
        acc   = cfg_if.cfg_valid && rdy;
        cc    = int'(cfg_if.cfg_ch);
        old_p = m_pending;
        nxt   = -1;
        if (m_armed[m_scan] && timer_value >= m_deadline[m_scan] && !(acc && cc == m_scan))
            nxt = m_scan;
        for (int k = 0; k < N_CH; k++)
            if (pend_clr[k] && m_inflight != k) begin
                m_pending[k] = 1'b0;
                m_overrun[k] = 1'b0;
            end
        if (m_inflight >= 0) begin
            h = m_inflight;
            m_pending[h] = 1'b1;
            if (old_p[h]) m_overrun[h] = 1'b1;
            else if (pend_clr[h]) m_overrun[h] = 1'b0;
            if (m_period[h] != 0) m_deadline[h] = m_deadline[h] + m_period[h];
            else m_armed[h] = 1'b0;
        end
        if (acc) begin
            if (cfg_if.cfg_arm) begin
                m_armed[cc]    = 1'b1;
                m_deadline[cc] = cfg_if.cfg_deadline;
`ifdef TIMER_ALARM_PERIODIC_EN
                m_period[cc]   = cfg_if.cfg_period;
`else
                m_period[cc]   = '0;
`endif
                m_pending[cc]  = 1'b0;
                m_overrun[cc]  = 1'b0;
            end else begin
                m_armed[cc] = 1'b0;
            end
        end
        m_inflight  = nxt;
        m_scan      = (m_scan + 1) % N_CH;
        last_accept = acc;
    endtask

    // One clock: compare all outputs mid-cycle, advance the model, return just after the edge.
    task automatic step();
        bit rdy;
        @(negedge clk);
        rdy = model_ready();
        chk("cfg_ready", 64'(cfg_if.cfg_ready), 64'(rdy));
        chk("armed",     64'(armed),     64'(m_armed));
        chk("pending",   64'(pending),   64'(m_pending));
        chk("overrun",   64'(overrun),   64'(m_overrun));
        chk("scan_ch",   64'(scan_ch),   64'(m_scan));
        chk("interrupt", 64'(interrupt), 64'(|(m_pending & irq_mask)));
        model_advance(rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input bit arm, input logic [63:0] dl, input logic [63:0] per);
        cfg_if.cfg_valid    = 1'b1;
        cfg_if.cfg_ch       = CH_W'(ch);
        cfg_if.cfg_arm      = arm;
        cfg_if.cfg_deadline = dl;
        cfg_if.cfg_period   = per;
        for (int i = 0; i < 4; i++) begin
            step();
            if (last_accept) break;
        end
        chk("cfg_accepted", 64'(last_accept), 64'd1);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_inflight(input int ch);
        bit seen = 0;
        for (int i = 0; i < 2 * N_CH + 2; i++) begin
            if (m_inflight == ch) begin
                seen = 1;
                break;
            end
            step();
        end
        chk("inflight_seen", 64'(seen), 64'd1);
    endtask

    task automatic clear_all();
        for (int k = 0; k < N_CH; k++) cfg_write(k, 1'b0, '0, '0);
        pend_clr = '1;
        step();
        pend_clr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_pend;
        int fires;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_arm = 1'b0;
        cfg_if.cfg_deadline = '0; cfg_if.cfg_period = '0;
        model_reset();

        #12;
        chk("rst_pending",   64'(pending),   64'd0);
        chk("rst_armed",     64'(armed),     64'd0);
        chk("rst_scan",      64'(scan_ch),   64'd0);
        chk("rst_interrupt", 64'(interrupt), 64'd0);
        chk("rst_ready",     64'(cfg_if.cfg_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // One-shot alarm on ch2 with a ramping timer
        irq_mask = 4'h4;
        timer_value = 64'd90;
        cfg_write(2, 1'b1, 64'd100, 64'd0);
        t_pend = -1;
        for (int i = 0; i < 30; i++) begin
            timer_value = 64'(90 + i);
            if (t_pend < 0 && pending[2]) t_pend = 90 + i;
            step();
        end
        chk("t1_latency_ok", 64'(t_pend >= 102 && t_pend <= 100 + N_CH + 1), 64'd1);
        chk("t1_disarmed", 64'(armed[2]), 64'd0);
        pend_clr = 4'h4;
        step();
        pend_clr = '0;
        chk("t1_clr_pending", 64'(pending[2]), 64'd0);
        chk("t1_clr_irq", 64'(interrupt), 64'd0);
        step();

`ifdef TIMER_ALARM_PERIODIC_EN
        // Periodic ch0 at 50, 70, 90
        irq_mask = 4'h1;
        timer_value = 64'd40;
        cfg_write(0, 1'b1, 64'd50, 64'd20);
        fires = 0;
        for (int i = 0; i < 70; i++) begin
            timer_value = (i < 60) ? 64'(40 + i) : 64'd100;
            pend_clr = '0;
            if (pending[0]) begin
                fires++;
                pend_clr = 4'h1;
            end
            step();
        end
        pend_clr = '0;
        chk("per_fire_count", 64'(fires), 64'd3);
        chk("per_still_armed", 64'(armed[0]), 64'd1);
        // Deadline near the top wraps to 10, so a maxed timer keeps re-firing
        timer_value = '1;
        cfg_write(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 64'd20);
        for (int i = 0; i < 3 * N_CH; i++) step();
        chk("wrap_overrun", 64'(overrun[1]), 64'd1);
        clear_all();
`endif

        // Catch-up with a tiny period while the timer is far ahead
        timer_value = 64'd1000;
        cfg_write(1, 1'b1, 64'd10, 64'd1);
        for (int i = 0; i < 2 * N_CH + 2; i++) step();
        chk("catchup_pending", 64'(pending[1]), 64'd1);
`ifdef TIMER_ALARM_PERIODIC_EN
        chk("catchup_overrun", 64'(overrun[1]), 64'd1);
`else
        chk("catchup_overrun", 64'(overrun[1]), 64'd0);
`endif
        clear_all();

        // Collision: write ch2 while its hit is in stage 2
        cfg_write(2, 1'b1, 64'd0, 64'd0);
        wait_inflight(2);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd2; cfg_if.cfg_arm = 1'b1;
        cfg_if.cfg_deadline = '1; cfg_if.cfg_period = '0;
        #1;
        chk("coll_ready_low", 64'(cfg_if.cfg_ready), 64'd0);
        cfg_write(2, 1'b1, '1, 64'd0);
        chk("coll_armed", 64'(armed[2]), 64'd1);
        chk("coll_pending", 64'(pending[2]), 64'd0);
        clear_all();

        // pend_clr racing a stage-2 hit on ch3
        cfg_write(3, 1'b1, 64'd0, 64'd0);
        wait_inflight(3);
        pend_clr = 4'h8;
        step();
        pend_clr = '0;
        chk("race_pending", 64'(pending[3]), 64'd1);
        clear_all();

        // Asynchronous reset with all channels armed and pending
        irq_mask = '1;
        for (int k = 0; k < N_CH; k++) cfg_write(k, 1'b1, 64'd0, 64'd0);
        for (int i = 0; i < 2 * N_CH; i++) step();
        chk("pre_rst_pending", 64'(pending), 64'hF);
        for (int k = 0; k < N_CH; k++) cfg_write(k, 1'b1, '1, 64'd0);
        for (int k = 0; k < N_CH; k++) cfg_write(k, 1'b1, 64'd0, 64'd0);
        for (int i = 0; i < N_CH + 2; i++) step();
        chk("pre_rst_armed_pend", 64'(pending | armed), 64'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pending",   64'(pending),   64'd0);
        chk("arst_overrun",   64'(overrun),   64'd0);
        chk("arst_armed",     64'(armed),     64'd0);
        chk("arst_scan",      64'(scan_ch),   64'd0);
        chk("arst_interrupt", 64'(interrupt), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_ready", 64'(cfg_if.cfg_ready), 64'd1);
        step();

        // Random traffic
        timer_value = 64'd1000;
        for (int i = 0; i < 600; i++) begin
            timer_value = timer_value + 64'($urandom_range(0, 3));
            irq_mask = N_CH'($urandom);
            pend_clr = ($urandom_range(0, 5) == 0) ? N_CH'($urandom) : '0;
            if (!cfg_if.cfg_valid && $urandom_range(0, 2) == 0) begin
                cfg_if.cfg_valid    = 1'b1;
                cfg_if.cfg_ch       = CH_W'($urandom_range(0, N_CH - 1));
                cfg_if.cfg_arm      = ($urandom_range(0, 4) != 0);
                cfg_if.cfg_deadline = timer_value + 64'($urandom_range(0, 40)) - 64'd10;
                cfg_if.cfg_period   = ($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom_range(1, 30));
            end
            step();
            if (last_accept) cfg_if.cfg_valid = 1'b0;
        end
        cfg_if.cfg_valid = 1'b0;
        pend_clr = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
